// File: rtl/comp_pkg.sv
// Shared types and helpers for the carry-save 4:2 accumulator.
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC     = 2'd1,
    RESOLVE = 2'd2,
    OUT     = 2'd3
  } state_t;

  // Headroom: two bits for the four operands of a beat plus log2 of the beat count.
  function automatic int acc_width(input int w, input int max_beats);
    return w + 2 + $clog2(max_beats);
  endfunction

  function automatic logic [63:0] extend(input logic [63:0] x, input int w, input logic sgn);
    logic [63:0] mask_s;
    logic        msb_s;
    mask_s = (64'd1 << w) - 64'd1;
    msb_s  = ((x >> (w - 1)) & 64'd1) != 64'd0;
    return (sgn && msb_s) ? (x | ~mask_s) : (x & mask_s);
  endfunction

endpackage

// File: rtl/comp42_row.sv
// One row of N exact 4:2 compressor cells with the lateral cout->cin ripple.
module comp42_row #(
  parameter int N = 12
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  input  logic [N-1:0] d,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);

  logic [N-1:0] cin_s;
  logic [N-1:0] t_s;

  assign cin_s[0] = 1'b0;
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign t_s[i] = a[i] ^ b[i] ^ c[i];
    assign sum[i] = t_s[i] ^ d[i] ^ cin_s[i];
    // Top-bit cout and carry fall outside the modulo-2^N window and are dropped.
    if (i < N - 1) begin : g_carry
      assign cin_s[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
      assign carry[i+1] = (t_s[i] & d[i]) | (t_s[i] & cin_s[i]) | (d[i] & cin_s[i]);
    end
  end

endmodule

// File: rtl/comp42_accumulator.sv
// Packetised four-operand carry-save accumulator with a single final carry-propagate add.
module comp42_accumulator
  import comp_pkg::*;
#(
  parameter  int W         = 8,
  parameter  int MAX_BEATS = 4,
  localparam int ACC_W     = acc_width(W, MAX_BEATS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic             in_signed,
  input  logic [W-1:0]     in_x1,
  input  logic [W-1:0]     in_x2,
  input  logic [W-1:0]     in_x3,
  input  logic [W-1:0]     in_x4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int                CNT_W   = $clog2(MAX_BEATS + 2);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0]  CNT_SAT = CNT_W'(MAX_BEATS + 1);

  state_t             state_r;
  logic [ACC_W-1:0]   s_r, c_r, out_sum_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               sign_r, in_ready_r, out_valid_r, out_ovf_r;

  logic               sign_sel_s, accept_s;
  logic [ACC_W-1:0]   x1e_s, x2e_s, x3e_s, x4e_s;
  logic [ACC_W-1:0]   s_in_s, c_in_s, sa_s, ca_s, s_nxt_s, c_nxt_s;

  assign accept_s = in_valid & in_ready_r;

  // First beat uses the live sign flag and a cleared accumulator; later beats use the latched state.
  always_comb begin
    sign_sel_s = sign_r;
    s_in_s     = s_r;
    c_in_s     = c_r;
    if (state_r == IDLE) begin
      sign_sel_s = in_signed;
      s_in_s     = {ACC_W{1'b0}};
      c_in_s     = {ACC_W{1'b0}};
    end else begin
      sign_sel_s = sign_r;
      s_in_s     = s_r;
      c_in_s     = c_r;
    end
  end

  assign x1e_s = ACC_W'(extend(64'(in_x1), W, sign_sel_s));
  assign x2e_s = ACC_W'(extend(64'(in_x2), W, sign_sel_s));
  assign x3e_s = ACC_W'(extend(64'(in_x3), W, sign_sel_s));
  assign x4e_s = ACC_W'(extend(64'(in_x4), W, sign_sel_s));

  comp42_row #(.N(ACC_W)) u_row_a (
    .a(x1e_s), .b(x2e_s), .c(x3e_s), .d(x4e_s), .sum(sa_s), .carry(ca_s)
  );

  comp42_row #(.N(ACC_W)) u_row_b (
    .a(sa_s), .b(ca_s), .c(s_in_s), .d(c_in_s), .sum(s_nxt_s), .carry(c_nxt_s)
  );

  // Packet sequencing, accumulation and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      s_r         <= {ACC_W{1'b0}};
      c_r         <= {ACC_W{1'b0}};
      out_sum_r   <= {ACC_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      sign_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            sign_r <= in_signed;
            s_r    <= s_nxt_s;
            c_r    <= c_nxt_s;
            cnt_r  <= CNT_W'(1);
            if (in_last) begin
              state_r    <= RESOLVE;
              in_ready_r <= 1'b0;
            end else begin
              state_r    <= ACC;
              in_ready_r <= 1'b1;
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ACC: begin
          if (accept_s) begin
            s_r <= s_nxt_s;
            c_r <= c_nxt_s;
            if (cnt_r != CNT_SAT) begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
            if (in_last) begin
              state_r    <= RESOLVE;
              in_ready_r <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          out_sum_r   <= s_r + c_r;
          out_ovf_r   <= (cnt_r > CNT_MAX);
          out_valid_r <= 1'b1;
          in_ready_r  <= 1'b0;
          state_r     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            s_r         <= {ACC_W{1'b0}};
            c_r         <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_comp42_accumulator.sv
// Directed and randomized checks of comp42_accumulator against an arithmetic reference model.
module tb_comp42_accumulator;

  localparam int W  = 8;
  localparam int MB = 4;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_last, in_signed, out_ready;
  logic [W-1:0]  in_x1, in_x2, in_x3, in_x4;
  logic          in_ready, out_valid, out_ovf;
  logic [AW-1:0] out_sum;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: plain integer sum of extended operands, sign mode taken from the first beat.
  int ref_acc   = 0;
  int ref_beats = 0;
  bit ref_sgn   = 1'b0;

  comp42_accumulator #(.W(W), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_signed(in_signed),
    .in_x1(in_x1), .in_x2(in_x2), .in_x3(in_x3), .in_x4(in_x4),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int ext(input logic [W-1:0] x, input bit sgn);
    return sgn ? int'($signed(x)) : int'(x);
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_beat(input logic [W-1:0] a, b, c, d, input logic sgn, input logic last);
    int n = 0;
    in_x1 = a; in_x2 = b; in_x3 = c; in_x4 = d;
    in_signed = sgn; in_last = last; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("beat_accept_timeout", 32'(n < 40), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (ref_beats == 0) ref_sgn = sgn;
    ref_acc = ref_acc + ext(a, ref_sgn) + ext(b, ref_sgn) + ext(c, ref_sgn) + ext(d, ref_sgn);
    ref_beats++;
  endtask

  task automatic expect_result(input string tag, input logic [AW-1:0] e_sum, input logic e_ovf);
    int n = 0;
    while (out_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid_timeout"}, 32'(n < 10), 32'd1);
    chk({tag, "_sum"}, 32'(out_sum), 32'(e_sum));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(e_ovf));
    out_ready = 1'b1;
    chk({tag, "_ready_in_handshake"}, 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    ref_acc   = 0;
    ref_beats = 0;
  endtask

  initial begin
    logic [W-1:0] v [4];
    int           nb;
    bit           sgn;

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_signed = 1'b0; out_ready = 1'b0;
    in_x1 = '0; in_x2 = '0; in_x3 = '0; in_x4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single beat with latency check.
    send_beat(8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 1'b1);
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_no_ready", 32'(in_ready), 32'd0);
    expect_result("single", 12'd10, 1'b0);

    for (int i = 0; i < 4; i++) send_beat(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'(i == 3));
    expect_result("uns_ff", 12'd4080, 1'b0);

    for (int i = 0; i < 4; i++) send_beat(8'h80, 8'h80, 8'h80, 8'h80, 1'b1, 1'(i == 3));
    expect_result("sgn_80", 12'h800, 1'b0);

    for (int i = 0; i < 4; i++) send_beat(8'h7F, 8'h81, 8'h05, 8'hFE, 1'b1, 1'(i == 3));
    expect_result("sgn_mix", 12'd12, 1'b0);

    for (int i = 0; i < 5; i++) send_beat(8'd1, 8'd1, 8'd1, 8'd1, 1'b0, 1'(i == 4));
    expect_result("ovf5", 12'd20, 1'b1);

    // Backpressure: result held stable while the consumer stalls.
    send_beat(8'd10, 8'd20, 8'd30, 8'd40, 1'b0, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(out_sum), 32'd100);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    expect_result("bp", 12'd100, 1'b0);

    // Reset mid-packet discards the partial accumulation.
    send_beat(8'd5, 8'd5, 8'd5, 8'd5, 1'b0, 1'b0);
    send_beat(8'd5, 8'd5, 8'd5, 8'd5, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_sum", 32'(out_sum), 32'd0);
    chk("mid_rst_ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;
    ref_acc = 0;
    ref_beats = 0;
    @(negedge clk);
    send_beat(8'd1, 8'd1, 8'd1, 8'd1, 1'b0, 1'b1);
    expect_result("post_rst", 12'd4, 1'b0);

    // Randomized packets; in_signed on later beats is random to show it is ignored.
    for (int p = 0; p < 25; p++) begin
      nb  = int'($urandom_range(1, 6));
      sgn = 1'($urandom_range(0, 1));
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < 4; k++) v[k] = W'($urandom);
        send_beat(v[0], v[1], v[2], v[3], (b == 0) ? sgn : 1'($urandom_range(0, 1)), 1'(b == nb - 1));
      end
      expect_result("rand", AW'(ref_acc), 1'(nb > MB));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
